// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared CPU pipeline widths, branch encodings and MEM/WB control bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_REG_W        = 6;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int CNT_W            = 3;

  localparam logic BR_ZERO = 1'b0;
  localparam logic BR_NEG  = 1'b1;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  // An invalid instruction must never assert a memory or register-file side effect.
  function automatic mem_ctrl_t gate_ctrl(input mem_ctrl_t c, input logic v);
    return v ? c : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/squash_ctr.sv
// ============================================================================
// Module : squash_ctr
// Brief  : 3-bit loadable down-counter; priority rst > hold > load > decrement.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module squash_ctr
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold) begin
      if (load) begin
        cnt_d = load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/exmem_buf.sv
// ============================================================================
// Module : exmem_buf
// Brief  : EX/MEM pipeline register with branch resolution and wrong-path squash.
//          Optional EXMEM_STATS_EN adds taken/squash event counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exmem_buf
  import cpu_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REG_W        = DEF_REG_W,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              branch_in,
  input  logic              branch_cond_in,
  input  logic              zero_in,
  input  logic              neg_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] branch_target_in,
  output logic              valid_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [DATA_W-1:0] branch_target_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              pc_src,
`ifdef EXMEM_STATS_EN
  output logic [15:0]       taken_cnt,
  output logic [15:0]       squash_cnt,
`endif
  output logic              flush_req
);

  localparam logic [CNT_W-1:0] C_FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  logic              valid_q,  valid_d;
  mem_ctrl_t         ctrl_q,   ctrl_d;
  logic [DATA_W-1:0] alu_q,    alu_d;
  logic [DATA_W-1:0] store_q,  store_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [REG_W-1:0]  rd_q,     rd_d;
  logic              pc_src_q, pc_src_d;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_nz;
  logic              squash;
  logic              cond_met;
  logic              taken;
  logic              bubble;
  logic [CNT_W-1:0]  cnt_load_val;
  mem_ctrl_t         ctrl_in;

  assign squash       = (cnt != '0);
  assign cond_met     = (branch_cond_in == BR_NEG) ? neg_in : zero_in;
  assign taken        = valid_in & branch_in & cond_met & ~squash & ~flush;
  assign bubble       = flush | squash;
  assign cnt_load_val = taken ? C_FLUSH_LOAD : '0;
  assign ctrl_in      = '{mem_read:   mem_read_in,
                          mem_write:  mem_write_in,
                          reg_write:  reg_write_in,
                          mem_to_reg: mem_to_reg_in};

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    alu_d    = alu_q;
    store_d  = store_q;
    target_d = target_q;
    rd_d     = rd_q;
    pc_src_d = pc_src_q;
    if (!stall) begin
      if (bubble) begin
        valid_d  = 1'b0;
        ctrl_d   = '0;
        alu_d    = '0;
        store_d  = '0;
        target_d = '0;
        rd_d     = '0;
        pc_src_d = 1'b0;
      end else begin
        valid_d  = valid_in;
        ctrl_d   = gate_ctrl(ctrl_in, valid_in);
        alu_d    = alu_result_in;
        store_d  = store_data_in;
        target_d = branch_target_in;
        rd_d     = rd_in;
        pc_src_d = taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      alu_q    <= '0;
      store_q  <= '0;
      target_q <= '0;
      rd_q     <= '0;
      pc_src_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      alu_q    <= alu_d;
      store_q  <= store_d;
      target_q <= target_d;
      rd_q     <= rd_d;
      pc_src_q <= pc_src_d;
    end
  end

  // A normal load always reloads the counter, which clears it for non-branches.
  squash_ctr u_squash_ctr (
    .clk      (clk),
    .rst      (rst),
    .hold     (stall),
    .load     (~bubble),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .nonzero  (cnt_nz)
  );

`ifdef EXMEM_STATS_EN
  logic [15:0] taken_cnt_q,  taken_cnt_d;
  logic [15:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (!stall) begin
      if (!bubble && taken && (taken_cnt_q != 16'hFFFF)) begin
        taken_cnt_d = taken_cnt_q + 16'd1;
      end
      if (squash && (squash_cnt_q != 16'hFFFF)) begin
        squash_cnt_d = squash_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

  assign valid_out         = valid_q;
  assign mem_read_out      = ctrl_q.mem_read;
  assign mem_write_out     = ctrl_q.mem_write;
  assign reg_write_out     = ctrl_q.reg_write;
  assign mem_to_reg_out    = ctrl_q.mem_to_reg;
  assign alu_result_out    = alu_q;
  assign store_data_out    = store_q;
  assign branch_target_out = target_q;
  assign rd_out            = rd_q;
  assign pc_src            = pc_src_q;
  assign flush_req         = cnt_nz;

endmodule

`default_nettype wire

// File: tb/tb_exmem_buf.sv
// ============================================================================
// Module : tb_exmem_buf
// Brief  : Directed-vector scoreboard bench for exmem_buf (FLUSH_CYCLES = 2).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_exmem_buf;

  typedef struct packed {
    logic rst, stall, flush, valid, br, cond, z, n, mr, mw, rw, m2r;
    logic [5:0]  rd;
    logic [31:0] alu, sd, tgt;
  } in_t;

  typedef struct packed {
    logic v, mr, mw, rw, m2r, pc, fr;
    logic [5:0]  rd;
    logic [31:0] alu, sd, tgt;
    logic [15:0] tk, sq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in, branch_in, branch_cond_in, zero_in, neg_in;
  logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic [31:0] alu_result_in, store_data_in, branch_target_in;
  logic [5:0]  rd_in;
  logic        valid_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out;
  logic [31:0] alu_result_out, store_data_out, branch_target_out;
  logic [5:0]  rd_out;
  logic        pc_src, flush_req;
`ifdef EXMEM_STATS_EN
  logic [15:0] taken_cnt, squash_cnt;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  exmem_buf dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .valid_in          (valid_in),
    .branch_in         (branch_in),
    .branch_cond_in    (branch_cond_in),
    .zero_in           (zero_in),
    .neg_in            (neg_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .reg_write_in      (reg_write_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .alu_result_in     (alu_result_in),
    .store_data_in     (store_data_in),
    .rd_in             (rd_in),
    .branch_target_in  (branch_target_in),
    .valid_out         (valid_out),
    .mem_read_out      (mem_read_out),
    .mem_write_out     (mem_write_out),
    .reg_write_out     (reg_write_out),
    .mem_to_reg_out    (mem_to_reg_out),
    .alu_result_out    (alu_result_out),
    .store_data_out    (store_data_out),
    .branch_target_out (branch_target_out),
    .rd_out            (rd_out),
    .pc_src            (pc_src),
`ifdef EXMEM_STATS_EN
    .taken_cnt         (taken_cnt),
    .squash_cnt        (squash_cnt),
`endif
    .flush_req         (flush_req)
  );

  function automatic in_t mk_in(logic valid, logic br, logic cond, logic z, logic n,
                                logic mr, logic mw, logic rw, logic m2r, logic [5:0] rd,
                                logic [31:0] alu, logic [31:0] sd, logic [31:0] tgt);
    in_t x;
    x = '0;
    x.valid = valid; x.br = br; x.cond = cond; x.z = z; x.n = n;
    x.mr = mr; x.mw = mw; x.rw = rw; x.m2r = m2r;
    x.rd = rd; x.alu = alu; x.sd = sd; x.tgt = tgt;
    return x;
  endfunction

  function automatic exp_t mk_exp(logic v, logic mr, logic mw, logic rw, logic m2r,
                                  logic [5:0] rd, logic [31:0] alu, logic [31:0] sd,
                                  logic [31:0] tgt, logic pc, logic fr,
                                  logic [15:0] tk, logic [15:0] sq);
    exp_t e;
    e.v = v; e.mr = mr; e.mw = mw; e.rw = rw; e.m2r = m2r;
    e.rd = rd; e.alu = alu; e.sd = sd; e.tgt = tgt; e.pc = pc; e.fr = fr;
    e.tk = tk; e.sq = sq;
    return e;
  endfunction

  task automatic vec(input in_t x, input exp_t e);
    @(negedge clk);
    rst = x.rst; stall = x.stall; flush = x.flush;
    valid_in = x.valid; branch_in = x.br; branch_cond_in = x.cond;
    zero_in = x.z; neg_in = x.n;
    mem_read_in = x.mr; mem_write_in = x.mw; reg_write_in = x.rw; mem_to_reg_in = x.m2r;
    rd_in = x.rd; alu_result_in = x.alu; store_data_in = x.sd; branch_target_in = x.tgt;
    sb_q.push_back(e);
  endtask

  // Monitor: the registered outputs are presented every cycle; check one entry per edge.
  always begin
    exp_t e, a;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a.v = valid_out; a.mr = mem_read_out; a.mw = mem_write_out;
      a.rw = reg_write_out; a.m2r = mem_to_reg_out; a.rd = rd_out;
      a.alu = alu_result_out; a.sd = store_data_out; a.tgt = branch_target_out;
      a.pc = pc_src; a.fr = flush_req;
      a.tk = '0; a.sq = '0;
      e.tk = e.tk; 
      total++;
      if ({a.v, a.mr, a.mw, a.rw, a.m2r, a.pc, a.fr, a.rd, a.alu, a.sd, a.tgt} !==
          {e.v, e.mr, e.mw, e.rw, e.m2r, e.pc, e.fr, e.rd, e.alu, e.sd, e.tgt}) begin
        bad++;
        $display("FAIL outputs t=%0t: got v%b mr%b mw%b rw%b m2r%b pc%b fr%b rd=%0d alu=%h sd=%h tgt=%h ; want v%b mr%b mw%b rw%b m2r%b pc%b fr%b rd=%0d alu=%h sd=%h tgt=%h",
                 $time, a.v, a.mr, a.mw, a.rw, a.m2r, a.pc, a.fr, a.rd, a.alu, a.sd, a.tgt,
                 e.v, e.mr, e.mw, e.rw, e.m2r, e.pc, e.fr, e.rd, e.alu, e.sd, e.tgt);
      end
`ifdef EXMEM_STATS_EN
      total++;
      if ({taken_cnt, squash_cnt} !== {e.tk, e.sq}) begin
        bad++;
        $display("FAIL stats t=%0t: got taken=%0d squash=%0d ; want taken=%0d squash=%0d",
                 $time, taken_cnt, squash_cnt, e.tk, e.sq);
      end
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  x;
    exp_t z;
    exp_t hold_e;
    z = '0;

    // Reset (two cycles)
    x = '0; x.rst = 1'b1;
    vec(x, z);
    vec(x, z);

    // Straight-line ALU op, invalid store, valid load
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd5, 32'h10, 32'h3, 32'h0),
        mk_exp(1,0,0,1,0, 6'd5, 32'h10, 32'h3, 32'h0, 0,0, 16'd0,16'd0));
    vec(mk_in(0,0,0,0,0, 0,1,1,0, 6'd7, 32'h20, 32'h55, 32'h0),
        mk_exp(0,0,0,0,0, 6'd7, 32'h20, 32'h55, 32'h0, 0,0, 16'd0,16'd0));
    vec(mk_in(1,0,0,0,0, 1,0,1,1, 6'd9, 32'h100, 32'h0, 32'h0),
        mk_exp(1,1,0,1,1, 6'd9, 32'h100, 32'h0, 32'h0, 0,0, 16'd0,16'd0));

    // BR_NEG untaken (zero set but irrelevant)
    vec(mk_in(1,1,1,1,0, 0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h80),
        mk_exp(1,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h80, 0,0, 16'd0,16'd0));

    // BR_ZERO taken, then two wrong-path instructions squashed, then a survivor
    vec(mk_in(1,1,0,1,0, 0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h40),
        mk_exp(1,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h40, 1,1, 16'd1,16'd0));
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd3, 32'h33, 32'h0, 32'h0),
        mk_exp(0,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h0, 0,1, 16'd1,16'd1));
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd4, 32'h44, 32'h0, 32'h0),
        mk_exp(0,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h0, 0,0, 16'd1,16'd2));
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd6, 32'h66, 32'h0, 32'h0),
        mk_exp(1,0,0,1,0, 6'd6, 32'h66, 32'h0, 32'h0, 0,0, 16'd1,16'd2));

    // BR_NEG taken, then stall 3 cycles inside the squash window
    hold_e = mk_exp(1,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h200, 1,1, 16'd2,16'd2);
    vec(mk_in(1,1,1,0,1, 0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h200), hold_e);
    for (int i = 0; i < 3; i++) begin
      x = mk_in(1,0,0,0,0, 0,0,1,0, 6'd8, 32'h88, 32'h0, 32'h0);
      x.stall = 1'b1;
      vec(x, hold_e);
    end
    // Wrong-path taken branch must not re-arm the counter
    vec(mk_in(1,1,0,1,0, 0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h300),
        mk_exp(0,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h0, 0,1, 16'd2,16'd3));
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd2, 32'h2, 32'h0, 32'h0),
        mk_exp(0,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h0, 0,0, 16'd2,16'd4));
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd2, 32'h22, 32'h0, 32'h0),
        mk_exp(1,0,0,1,0, 6'd2, 32'h22, 32'h0, 32'h0, 0,0, 16'd2,16'd4));

    // Flush together with a taken branch: branch dropped, no squash window
    x = mk_in(1,1,0,1,0, 0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h500);
    x.flush = 1'b1;
    vec(x, z | mk_exp(0,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h0, 0,0, 16'd2,16'd4));
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd1, 32'h11, 32'h0, 32'h0),
        mk_exp(1,0,0,1,0, 6'd1, 32'h11, 32'h0, 32'h0, 0,0, 16'd2,16'd4));

    // Taken branch, one squash, then reset with cnt = 1
    vec(mk_in(1,1,0,1,0, 0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h600),
        mk_exp(1,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h600, 1,1, 16'd3,16'd4));
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd12, 32'h12, 32'h0, 32'h0),
        mk_exp(0,0,0,0,0, 6'd0, 32'h0, 32'h0, 32'h0, 0,1, 16'd3,16'd5));
    x = mk_in(1,0,0,0,0, 0,0,1,0, 6'd13, 32'h13, 32'h0, 32'h0);
    x.rst = 1'b1;
    vec(x, z);
    vec(mk_in(1,0,0,0,0, 0,0,1,0, 6'd11, 32'hB, 32'h7, 32'h0),
        mk_exp(1,0,0,1,0, 6'd11, 32'hB, 32'h7, 32'h0, 0,0, 16'd0,16'd0));

    // External flush of a store, then stall holds the bubble, then the store lands
    x = mk_in(1,0,0,0,0, 0,1,0,0, 6'd0, 32'h44, 32'h9, 32'h0);
    x.flush = 1'b1;
    vec(x, z);
    x = mk_in(1,0,0,0,0, 0,0,1,0, 6'd3, 32'h77, 32'h0, 32'h0);
    x.stall = 1'b1;
    vec(x, z);
    vec(mk_in(1,0,0,0,0, 0,1,0,0, 6'd0, 32'h44, 32'h9, 32'h0),
        mk_exp(1,0,1,0,0, 6'd0, 32'h44, 32'h9, 32'h0, 0,0, 16'd0,16'd0));

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exmem_buf.md
Name: exmem_buf

Overview:
EX/MEM pipeline register. Sits directly downstream of the ID/EX buffer and ALU, and feeds the data-memory stage.
- Captures EX-stage results and the control bits that survive into MEM/WB.
- Resolves conditional branches and drives the PC-source select.
- Runs a squash counter that kills wrong-path instructions after a taken branch.

Parameters:
DATA_W, 32, width of ALU result, store data and branch target
REG_W, 6, destination register index width
FLUSH_CYCLES, 2, number of younger instructions squashed after a taken branch (1..7)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
stall  in  1  hold all state this cycle
flush  in  1  external bubble insert
valid_in  in  1  EX instruction is real
branch_in  in  1  EX instruction is a conditional branch
branch_cond_in  in  1  0 = branch if zero, 1 = branch if negative
zero_in  in  1  ALU zero flag
neg_in  in  1  ALU negative flag
mem_read_in  in  1  load
mem_write_in  in  1  store
reg_write_in  in  1  writes register file
mem_to_reg_in  in  1  WB selects memory data
alu_result_in  in  DATA_W  ALU output / memory address
store_data_in  in  DATA_W  rt value for stores
rd_in  in  REG_W  destination register
branch_target_in  in  DATA_W  computed target
valid_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out  out  1  registered copies
alu_result_out, store_data_out, branch_target_out  out  DATA_W  registered copies
rd_out  out  REG_W  registered copy
pc_src  out  1  registered branch-taken; selects branch_target_out at the PC mux
flush_req  out  1  high while squash counter is nonzero; upstream buffers insert bubbles

Behaviour:
- All state is updated on posedge clk. Latency is 1 cycle.
- Reset: every output is 0 and cnt = 0. A reset mid-countdown clears cnt immediately.
- Priority: rst > stall > (flush | squash) > load.
- squash = (cnt != 0).
- taken = valid_in & branch_in & (branch_cond_in ? neg_in : zero_in) & ~squash & ~flush.
- Stall: all outputs and cnt hold. pc_src is held too; upstream holds the PC while stalled.
- flush or squash (not stalled): load a bubble.
  - valid_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out, pc_src = 0.
  - alu_result_out, store_data_out, branch_target_out = 0; rd_out = 0.
  - cnt decrements if nonzero.
- Normal load: every *_out takes its *_in. Control outputs are ANDed with valid_in, so an invalid instruction never asserts memory or register-write.
  - pc_src <= taken.
  - cnt <= taken ? FLUSH_CYCLES : 0.
- pc_src is a one-cycle pulse per taken branch, except when stretched by stall.
- A branch arriving while squash is active is wrong-path: it is squashed and never re-arms cnt.
- Simultaneous flush and taken branch: flush wins and the branch is dropped.
- Non-branch and untaken instructions never modify cnt except the normal decrement/clear.

Optional Feature:
EXMEM_STATS_EN
- Defined: adds outputs taken_cnt[15:0] and squash_cnt[15:0].
  - taken_cnt increments on each registered taken branch.
  - squash_cnt increments on each cycle that loads a bubble because of squash (not external flush).
  - Both saturate at 16'hFFFF, clear on rst, and hold on stall.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cpu_pkg holds:
  - DATA_W and REG_W defaults
  - FLUSH_CYCLES default
  - branch-condition constants BR_ZERO = 0, BR_NEG = 1
  - a packed typedef for the MEM/WB control bundle (mem_read, mem_write, reg_write, mem_to_reg)
- Sub-module squash_ctr: a 3-bit loadable down-counter with inputs load, load_val, hold and outputs cnt and nonzero. It is reused by the IF/ID hazard logic.

Test Plan:
- Straight-line: ALU op rd = 5, result 0x0000_0010, reg_write = 1 -> next cycle rd_out = 5, alu_result_out = 0x10, reg_write_out = 1, pc_src = 0, flush_req = 0.
- BR_ZERO taken: branch_in = 1, zero_in = 1, target 0x40 -> next cycle pc_src = 1, branch_target_out = 0x40, flush_req = 1 for 2 cycles; the two following valid instructions emerge with valid_out = 0 and reg_write_out = 0.
- BR_NEG untaken (neg_in = 0): pc_src = 0, flush_req stays 0, no squash.
- Stall in the middle of a squash window: after a taken branch, stall for 3 cycles -> outputs frozen and flush_req stays 1; flush_req drops only after 2 unstalled cycles.
- Simultaneous flush = 1 with a taken branch -> bubble registered, pc_src = 0, cnt = 0.
- rst asserted with cnt = 1 -> next cycle all outputs 0, flush_req = 0; if EXMEM_STATS_EN is defined, both counters read 0.
